// File: rtl/wb_rst_seq.sv
// Reset sequencer: synchronizes board reset release, staggers per-channel resets,
// and re-sequences on software request or a Wishbone bus-hang watchdog trip.
//
// state | meaning
// HOLD  | board reset released, waiting for the release synchronizer
// COUNT | stagger counter running, channels released one by one
// RUN   | every channel released, watchdog armed
// SOFT  | soft reset: all channels held for RST_DELAY cycles
module wb_rst_seq #(
  parameter int NUM_CH      = 2,
  parameter int RST_DELAY   = 10,
  parameter int CH_STAGGER  = 4,
  parameter int SYNC_STAGES = 2,
  parameter int WDOG_CYCLES = 1000,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sw_rst_req,
  input  logic              wdog_en,
  input  logic              wb_cyc_i,
  input  logic              wb_ack_i,
  output logic [NUM_CH-1:0] rst_out,
  output logic              all_ready,
  output logic              wdog_trip,
  output logic [7:0]        trip_count
);

  if (NUM_CH < 1) begin : g_chk_num_ch
    $error("wb_rst_seq: NUM_CH must be >= 1");
  end
  if (RST_DELAY < 1) begin : g_chk_delay
    $error("wb_rst_seq: RST_DELAY must be >= 1");
  end
  if (SYNC_STAGES < 2) begin : g_chk_sync
    $error("wb_rst_seq: SYNC_STAGES must be >= 2");
  end
  if (WDOG_CYCLES < 1) begin : g_chk_wdog
    $error("wb_rst_seq: WDOG_CYCLES must be >= 1");
  end
  if (longint'(RST_DELAY + (NUM_CH-1)*CH_STAGGER) > (longint'(1) << CNT_W) - longint'(1))
  begin : g_chk_cnt_w
    $error("wb_rst_seq: CNT_W too small for the stagger schedule");
  end
  if (longint'(WDOG_CYCLES) > (longint'(1) << CNT_W) - longint'(1)) begin : g_chk_wd_w
    $error("wb_rst_seq: CNT_W too small for WDOG_CYCLES");
  end

  typedef enum logic [1:0] {HOLD, COUNT, RUN, SOFT} state_t;

  localparam logic [CNT_W-1:0] RD_M1  = CNT_W'(RST_DELAY - 1);
  localparam logic [CNT_W-1:0] WD_M1  = CNT_W'(WDOG_CYCLES - 1);
  localparam logic [CNT_W-1:0] T_LAST = CNT_W'(RST_DELAY + (NUM_CH-1)*CH_STAGGER);

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-2:0] sync_q;
  logic [CNT_W-1:0]       cnt_q, cnt_d, wd_q, wd_d;
  logic [NUM_CH-1:0]      rst_out_d;
  logic                   all_ready_d, trip, stall;
  logic [7:0]             trip_count_d;

  // The HOLD->COUNT decision registers the last synchronizer stage, so the
  // chain proper only needs SYNC_STAGES-1 flops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= 1'b1;
      for (int i = 1; i < SYNC_STAGES-1; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign stall = wdog_en & wb_cyc_i & ~wb_ack_i;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    wd_d         = '0;
    rst_out_d    = rst_out;
    all_ready_d  = all_ready;
    trip         = 1'b0;
    trip_count_d = trip_count;
    case (state_q)
      HOLD: begin
        cnt_d = '0;
        if (sync_q[SYNC_STAGES-2]) state_d = COUNT;
      end
      COUNT: begin
        cnt_d = cnt_q + 1'b1;
        for (int k = 0; k < NUM_CH; k++) begin
          if (cnt_q == CNT_W'(RST_DELAY + k*CH_STAGGER)) rst_out_d[k] = 1'b0;
        end
        if (cnt_q == T_LAST) begin
          state_d     = RUN;
          all_ready_d = 1'b1;
          cnt_d       = '0;
        end
      end
      RUN: begin
        rst_out_d = '0;
        if (stall) begin
          if (wd_q == WD_M1) trip = 1'b1;
          else               wd_d = wd_q + 1'b1;
        end
        if (trip && trip_count != 8'hFF) trip_count_d = trip_count + 1'b1;
        if (sw_rst_req || trip) begin
          state_d     = SOFT;
          rst_out_d   = '1;
          all_ready_d = 1'b0;
          cnt_d       = '0;
        end
      end
      SOFT: begin
        if (cnt_q == RD_M1) begin
          state_d = COUNT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = HOLD;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= HOLD;
      cnt_q      <= '0;
      wd_q       <= '0;
      rst_out    <= '1;
      all_ready  <= 1'b0;
      wdog_trip  <= 1'b0;
      trip_count <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wd_q       <= wd_d;
      rst_out    <= rst_out_d;
      all_ready  <= all_ready_d;
      wdog_trip  <= trip;
      trip_count <= trip_count_d;
    end
  end

endmodule

// File: tb/tb_wb_rst_seq.sv
// Directed bench for wb_rst_seq: a 2-channel staggered instance with a short
// watchdog, plus a 4-channel zero-stagger instance sharing the same stimulus.
module tb_wb_rst_seq;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sw_rst_req = 1'b0;
  logic       wdog_en = 1'b0;
  logic       wb_cyc_i = 1'b0;
  logic       wb_ack_i = 1'b0;
  logic [1:0] rst_out;
  logic       all_ready, wdog_trip;
  logic [7:0] trip_count;
  logic [3:0] b_rst_out;
  logic       b_all_ready, b_wdog_trip;
  logic [7:0] b_trip_count;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_rst_seq #(.NUM_CH(2), .RST_DELAY(10), .CH_STAGGER(4), .SYNC_STAGES(2),
               .WDOG_CYCLES(20), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .sw_rst_req(sw_rst_req), .wdog_en(wdog_en),
    .wb_cyc_i(wb_cyc_i), .wb_ack_i(wb_ack_i), .rst_out(rst_out),
    .all_ready(all_ready), .wdog_trip(wdog_trip), .trip_count(trip_count));

  wb_rst_seq #(.NUM_CH(4), .RST_DELAY(10), .CH_STAGGER(0), .SYNC_STAGES(2),
               .WDOG_CYCLES(20), .CNT_W(16)) dut_b (
    .clk(clk), .rst(rst), .sw_rst_req(sw_rst_req), .wdog_en(wdog_en),
    .wb_cyc_i(wb_cyc_i), .wb_ack_i(wb_ack_i), .rst_out(b_rst_out),
    .all_ready(b_all_ready), .wdog_trip(b_wdog_trip), .trip_count(b_trip_count));

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    checks++; if (rst_out !== 2'b11) begin errors++; $display("FAIL reset_rst_out got=%b exp=11", rst_out); end
    checks++; if (all_ready !== 1'b0) begin errors++; $display("FAIL reset_all_ready got=%b exp=0", all_ready); end
    checks++; if (wdog_trip !== 1'b0) begin errors++; $display("FAIL reset_wdog_trip got=%b exp=0", wdog_trip); end
    checks++; if (trip_count !== 8'd0) begin errors++; $display("FAIL reset_trip_count got=%0d exp=0", trip_count); end
    checks++; if (b_rst_out !== 4'hF) begin errors++; $display("FAIL reset_b_rst_out got=%b exp=1111", b_rst_out); end
    checks++; if (b_all_ready !== 1'b0 || b_wdog_trip !== 1'b0 || b_trip_count !== 8'd0) begin
      errors++; $display("FAIL reset_b_misc got=%b/%b/%0d exp=0/0/0", b_all_ready, b_wdog_trip, b_trip_count);
    end
  endtask

  // Release at edge 0; COUNT entered at edge 2; ch0 at edge 13, ch1 at edge 17.
  task automatic test_cold_start;
    rst = 1'b0;
    step(2);
    rst = 1'b1;
    step(12);
    checks++; if (rst_out !== 2'b11) begin errors++; $display("FAIL cold_e12 rst_out got=%b exp=11", rst_out); end
    checks++; if (b_rst_out !== 4'hF) begin errors++; $display("FAIL cold_e12 b_rst_out got=%b exp=1111", b_rst_out); end
    step(1);
    checks++; if (rst_out !== 2'b10 || all_ready !== 1'b0) begin
      errors++; $display("FAIL cold_e13 rst_out/all_ready got=%b/%b exp=10/0", rst_out, all_ready);
    end
    checks++; if (b_rst_out !== 4'h0 || b_all_ready !== 1'b1) begin
      errors++; $display("FAIL cold_e13 b_rst_out/all_ready got=%b/%b exp=0000/1", b_rst_out, b_all_ready);
    end
    step(3);
    checks++; if (rst_out !== 2'b10) begin errors++; $display("FAIL cold_e16 rst_out got=%b exp=10", rst_out); end
    step(1);
    checks++; if (rst_out !== 2'b00 || all_ready !== 1'b1) begin
      errors++; $display("FAIL cold_e17 rst_out/all_ready got=%b/%b exp=00/1", rst_out, all_ready);
    end
  endtask

  task automatic test_sw_rst;
    sw_rst_req = 1'b1;
    step(1);
    sw_rst_req = 1'b0;
    checks++; if (rst_out !== 2'b11 || all_ready !== 1'b0) begin
      errors++; $display("FAIL sw_entry rst_out/all_ready got=%b/%b exp=11/0", rst_out, all_ready);
    end
    step(10);
    checks++; if (rst_out !== 2'b11) begin errors++; $display("FAIL sw_hold rst_out got=%b exp=11", rst_out); end
    step(10);
    checks++; if (rst_out !== 2'b11) begin errors++; $display("FAIL sw_e20 rst_out got=%b exp=11", rst_out); end
    step(1);
    checks++; if (rst_out !== 2'b10) begin errors++; $display("FAIL sw_e21 rst_out got=%b exp=10", rst_out); end
    step(4);
    checks++; if (rst_out !== 2'b00 || all_ready !== 1'b1) begin
      errors++; $display("FAIL sw_e25 rst_out/all_ready got=%b/%b exp=00/1", rst_out, all_ready);
    end
    checks++; if (trip_count !== 8'd0) begin errors++; $display("FAIL sw_trip_count got=%0d exp=0", trip_count); end
  endtask

  task automatic test_watchdog;
    logic seen;
    wdog_en = 1'b1; wb_cyc_i = 1'b1; wb_ack_i = 1'b0;
    step(19);
    checks++; if (wdog_trip !== 1'b0 || all_ready !== 1'b1) begin
      errors++; $display("FAIL wd_early wdog_trip/all_ready got=%b/%b exp=0/1", wdog_trip, all_ready);
    end
    step(1);
    checks++; if (wdog_trip !== 1'b1 || trip_count !== 8'd1 || rst_out !== 2'b11) begin
      errors++; $display("FAIL wd_trip trip/count/rst_out got=%b/%0d/%b exp=1/1/11", wdog_trip, trip_count, rst_out);
    end
    wb_cyc_i = 1'b0;
    step(1);
    checks++; if (wdog_trip !== 1'b0) begin errors++; $display("FAIL wd_pulse_width got=%b exp=0", wdog_trip); end
    step(24);
    checks++; if (rst_out !== 2'b00 || all_ready !== 1'b1) begin
      errors++; $display("FAIL wd_reseq rst_out/all_ready got=%b/%b exp=00/1", rst_out, all_ready);
    end
    // ack lands in the would-be trip cycle
    wb_cyc_i = 1'b1;
    step(19);
    wb_ack_i = 1'b1;
    step(1);
    wb_ack_i = 1'b0;
    checks++; if (wdog_trip !== 1'b0 || all_ready !== 1'b1) begin
      errors++; $display("FAIL wd_ack_wins trip/all_ready got=%b/%b exp=0/1", wdog_trip, all_ready);
    end
    seen = 1'b0;
    for (int i = 0; i < 19; i++) begin
      step(1);
      seen = seen | wdog_trip;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL wd_restart_early got=%b exp=0", seen); end
    step(1);
    checks++; if (wdog_trip !== 1'b1 || trip_count !== 8'd2) begin
      errors++; $display("FAIL wd_restart_trip trip/count got=%b/%0d exp=1/2", wdog_trip, trip_count);
    end
    wb_cyc_i = 1'b0;
    step(25);
    checks++; if (all_ready !== 1'b1) begin errors++; $display("FAIL wd_back_to_run got=%b exp=1", all_ready); end
  endtask

  task automatic test_simultaneous;
    wb_cyc_i = 1'b1;
    step(19);
    sw_rst_req = 1'b1;
    step(1);
    sw_rst_req = 1'b0; wb_cyc_i = 1'b0;
    checks++; if (wdog_trip !== 1'b1 || trip_count !== 8'd3 || rst_out !== 2'b11 || all_ready !== 1'b0) begin
      errors++; $display("FAIL simul trip/count/rst_out/rdy got=%b/%0d/%b/%b exp=1/3/11/0",
                         wdog_trip, trip_count, rst_out, all_ready);
    end
    step(21);
    checks++; if (rst_out !== 2'b10) begin errors++; $display("FAIL simul_e21 rst_out got=%b exp=10", rst_out); end
    step(4);
    checks++; if (rst_out !== 2'b00 || all_ready !== 1'b1) begin
      errors++; $display("FAIL simul_e25 rst_out/all_ready got=%b/%b exp=00/1", rst_out, all_ready);
    end
  endtask

  task automatic test_sw_hold;
    sw_rst_req = 1'b1;
    step(1);
    checks++; if (rst_out !== 2'b11) begin errors++; $display("FAIL hold_entry rst_out got=%b exp=11", rst_out); end
    step(15);
    checks++; if (rst_out !== 2'b11) begin errors++; $display("FAIL hold_e15 rst_out got=%b exp=11", rst_out); end
    step(6);
    checks++; if (rst_out !== 2'b10) begin errors++; $display("FAIL hold_e21 rst_out got=%b exp=10", rst_out); end
    step(4);
    checks++; if (rst_out !== 2'b00 || all_ready !== 1'b1) begin
      errors++; $display("FAIL hold_e25 rst_out/all_ready got=%b/%b exp=00/1", rst_out, all_ready);
    end
    step(1);
    sw_rst_req = 1'b0;
    checks++; if (rst_out !== 2'b11 || all_ready !== 1'b0) begin
      errors++; $display("FAIL hold_reentry rst_out/all_ready got=%b/%b exp=11/0", rst_out, all_ready);
    end
    step(21);
    checks++; if (rst_out !== 2'b10) begin errors++; $display("FAIL hold2_e21 rst_out got=%b exp=10", rst_out); end
    step(4);
    checks++; if (rst_out !== 2'b00 || trip_count !== 8'd3) begin
      errors++; $display("FAIL hold2_e25 rst_out/count got=%b/%0d exp=00/3", rst_out, trip_count);
    end
  endtask

  task automatic wait_trip;
    int n;
    n = 0;
    while (wdog_trip !== 1'b1 && n < 100) begin
      step(1);
      n++;
    end
    checks++; if (wdog_trip !== 1'b1) begin errors++; $display("FAIL wait_trip timeout got=%b exp=1", wdog_trip); end
    step(1);
  endtask

  task automatic test_saturation;
    wdog_en = 1'b1; wb_cyc_i = 1'b1;
    for (int i = 0; i < 252; i++) wait_trip();
    checks++; if (trip_count !== 8'd255) begin errors++; $display("FAIL sat_255 got=%0d exp=255", trip_count); end
    wait_trip();
    checks++; if (trip_count !== 8'd255) begin errors++; $display("FAIL sat_no_wrap got=%0d exp=255", trip_count); end
    rst = 1'b0;
    #1;
    checks++; if (trip_count !== 8'd0 || rst_out !== 2'b11 || all_ready !== 1'b0) begin
      errors++; $display("FAIL sat_async_rst count/rst_out/rdy got=%0d/%b/%b exp=0/11/0", trip_count, rst_out, all_ready);
    end
    checks++; if (b_rst_out !== 4'hF) begin errors++; $display("FAIL sat_async_rst_b got=%b exp=1111", b_rst_out); end
    wdog_en = 1'b0; wb_cyc_i = 1'b0;
  endtask

  task automatic test_async_mid;
    test_cold_start();
    sw_rst_req = 1'b1;
    step(1);
    sw_rst_req = 1'b0;
    step(3);
    rst = 1'b0;
    #1;
    checks++; if (rst_out !== 2'b11 || all_ready !== 1'b0) begin
      errors++; $display("FAIL mid_soft_rst rst_out/rdy got=%b/%b exp=11/0", rst_out, all_ready);
    end
    test_cold_start();
    rst = 1'b0;
    step(2);
    rst = 1'b1;
    step(14);
    checks++; if (rst_out !== 2'b10) begin errors++; $display("FAIL mid_count_pre got=%b exp=10", rst_out); end
    rst = 1'b0;
    #1;
    checks++; if (rst_out !== 2'b11 || b_rst_out !== 4'hF || b_all_ready !== 1'b0) begin
      errors++; $display("FAIL mid_count_rst rst_out/b_rst_out/b_rdy got=%b/%b/%b exp=11/1111/0",
                         rst_out, b_rst_out, b_all_ready);
    end
    test_cold_start();
  endtask

  initial begin
    #3 rst = 1'b0;
    #1;
    test_reset();
    test_cold_start();
    test_sw_rst();
    test_watchdog();
    test_simultaneous();
    test_sw_hold();
    test_saturation();
    test_async_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
